uart_rx_async: RTL
==================

# uart_rx_async

UART receive engine paired with the CoreUARTapb transmit path. It recovers asynchronous serial frames from the `rx` line using a 16x oversampling baud enable, and checks start, data, parity and stop bits. Completed bytes go to a holding register with a ready flag, or to the receive FIFO. It sits beside the transmitter under the CoreUARTapb top and shares its baud generator, `bit8`, `parity_en` and `odd_n_even` controls.

## Interface
- `RX_FIFO`, 0 — 0 = holding register + `rx_ready`; 1 = write each byte to external RX FIFO
- `clk` in 1 — system clock
- `reset_n` in 1 — asynchronous, active-low reset
- `baud_clock` in 1 — one-clk enable pulse at 16x baud rate
- `rx` in 1 — serial line, asynchronous, idle high
- `bit8` in 1 — 1 = 8 data bits, 0 = 7
- `parity_en` in 1 — parity bit present
- `odd_n_even` in 1 — 1 = odd parity, 0 = even
- `read_rx_byte` in 1 — one-clk pulse, host consumed `rx_byte` (RX_FIFO=0)
- `clear_status` in 1 — one-clk pulse, clears sticky error flags
- `fifo_full` in 1 — RX FIFO full (RX_FIFO=1)
- `rx_byte` out 8 — received data, LSB first on line; bit 7 = 0 in 7-bit mode
- `rx_ready` out 1 — byte available (RX_FIFO=0; tied 0 when RX_FIFO=1)
- `fifo_write_n` out 1 — active-low one-clk FIFO write strobe, data on `rx_byte`
- `parity_err`, `framing_err`, `overflow` out 1 each — sticky status

## Operation
- `rx` passes through a 2-flop synchronizer, reset value 1. Start detection uses a falling edge of the synchronized line, meaning previous sample 1 and current sample 0.
- 4-bit `sample_cnt` advances on `baud_clock`. The bit is sampled when `sample_cnt` = 7 (mid-bit). There are 16 ticks per bit.
- States:
  - `rx_idle`: wait for falling edge; clear `sample_cnt`; go to `rx_start`.
  - `rx_start`: at sample point, if line = 0 go to `rx_data`, else go to `rx_idle` (glitch rejected, nothing written).
  - `rx_data`: shift the sampled bit into `bit_cnt` position. After bit 6 (7-bit mode) or bit 7 (8-bit mode), go to `rx_parity` if `parity_en`, else `rx_stop`.
  - `rx_parity`: compare the sampled bit with `odd_n_even ^ ^data`. A mismatch sets the pending parity error.
  - `rx_stop`: at sample point, stop = 0 sets the pending framing error. In the same cycle the state goes to `rx_commit`.
  - `rx_commit`: one clk. Perform the write/load and flag update, then go to `rx_idle`. A new start is accepted from the next clk, half a bit before the nominal stop end.
- Commit, RX_FIFO=0:
  - If `rx_ready` = 0 or `read_rx_byte` is high this cycle: load `rx_byte` and set `rx_ready`.
  - Else set `overflow`, discard the new byte, and keep `rx_byte`.
- Commit, RX_FIFO=1:
  - If `fifo_full` = 0: drive `fifo_write_n` = 0 for this clk.
  - Else set `overflow` and do not write.
- Bytes that carry parity or framing errors are still delivered. The error flags are set in the commit cycle.
- `read_rx_byte` clears `rx_ready`. Commit and read in the same clk: new byte loaded, `rx_ready` stays 1.
- `clear_status` clears the three error flags. A set in the same clk wins.
- Config inputs are sampled live and must be stable during a frame. Changing them mid-frame gives an undefined byte, but the FSM always returns to `rx_idle`.

## Timing
- Reset values: `rx_byte` = 0, `rx_ready` = 0, `fifo_write_n` = 1, all error flags 0, state `rx_idle`, synchronizer = 1.
- Edge detection lags the line by 2–3 clks.
- Commit occurs 1 clk after the stop-bit sample tick. `rx_ready`/`rx_byte` become visible the clk after commit.
- Reset asserted mid-frame aborts immediately. After release, if the line is held low, no start is taken until the line goes high then low.
- Break (line held low): one frame with `framing_err` and data 0x00. No further frames until the line returns high.

## Structure
- Shared package `uart_pkg`:
  - state encodings: `rx_idle`, `rx_start`, `rx_data`, `rx_parity`, `rx_stop`, `rx_commit`
  - `OVERSAMPLE` = 16
  - `SAMPLE_POINT` = 7
- One sub-module `uart_rx_sync`: 2-flop synchronizer plus falling-edge detector. It outputs `rx_sync` and `rx_fall`.

## Test plan
- 8N1, `baud_clock` every 4 clks, send 0xA5. Required: `rx_byte` = 0xA5, `rx_ready` = 1, no errors. After `read_rx_byte`, `rx_ready` = 0.
- 7E1 (`bit8`=0, `parity_en`=1, `odd_n_even`=0), send 0x35 with a wrong parity bit. Required: `rx_byte` = 0x35, `parity_err` = 1. After `clear_status`, `parity_err` = 0.
- 8N1, send 0x3C with stop bit = 0. Required: `rx_byte` = 0x3C, `framing_err` = 1.
- Line low for 5 ticks, then high. Required: start rejected, state back in `rx_idle`, `rx_ready` stays 0.
- RX_FIFO=0: send 0x11 then 0x22 without reading. Required: `rx_byte` = 0x11, `overflow` = 1.
- RX_FIFO=1: send 0x55 with `fifo_full` = 0, then 0x66 with `fifo_full` = 1. Required: exactly one `fifo_write_n` low pulse, with 0x55, and `overflow` = 1. Separately, assert `reset_n` mid-byte and require all outputs at reset values.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver state encodings, oversampling constants
// and the expected-parity helper.
package uart_pkg;

  localparam int unsigned STATE_W      = 3;
  localparam int unsigned SAMPLE_W     = 4;
  localparam int unsigned BITCNT_W     = 3;
  localparam int unsigned DATA_W       = 8;
  localparam int unsigned OVERSAMPLE   = 16;
  localparam int unsigned SAMPLE_POINT = 7;

  localparam logic [STATE_W-1:0] rx_idle   = 3'd0;
  localparam logic [STATE_W-1:0] rx_start  = 3'd1;
  localparam logic [STATE_W-1:0] rx_data   = 3'd2;
  localparam logic [STATE_W-1:0] rx_parity = 3'd3;
  localparam logic [STATE_W-1:0] rx_stop   = 3'd4;
  localparam logic [STATE_W-1:0] rx_commit = 3'd5;

  // Parity bit value that a correct frame carries for the given data.
  function automatic logic parity_expect(input logic [DATA_W-1:0] data, input logic odd_n_even);
    return odd_n_even ^ (^data);
  endfunction

endpackage

// File: rtl/uart_rx_sync.sv
// Two-flop synchronizer for the async rx line plus a falling-edge detector
// that only fires once the line has been seen high after reset.
module uart_rx_sync
  import uart_pkg::*;
(
  input  logic clk,
  input  logic reset_n,
  input  logic rx,
  output logic rx_sync,
  output logic rx_fall
);

  logic [1:0] sync_ff;
  logic       rx_prev;
  logic [1:0] flush;
  logic       armed;

  // armed waits for the flushed synchronizer to show a real high level, so a
  // line held low through reset never looks like a start edge.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync_ff <= 2'b11;
      rx_prev <= 1'b1;
      flush   <= 2'b00;
      armed   <= 1'b0;
    end else begin
      sync_ff <= {sync_ff[0], rx};
      rx_prev <= sync_ff[1];
      flush   <= {flush[0], 1'b1};
      armed   <= armed | (flush[1] & sync_ff[1]);
    end
  end

  assign rx_sync = sync_ff[1];
  assign rx_fall = armed & rx_prev & ~sync_ff[1];

endmodule

// File: rtl/uart_rx_async.sv
// UART receive engine: 16x oversampled frame recovery with parity/framing
// checks, delivering bytes to a holding register or an external FIFO.
module uart_rx_async
  import uart_pkg::*;
#(
  parameter bit RX_FIFO = 1'b0
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              baud_clock,
  input  logic              rx,
  input  logic              bit8,
  input  logic              parity_en,
  input  logic              odd_n_even,
  input  logic              read_rx_byte,
  input  logic              clear_status,
  input  logic              fifo_full,
  output logic [DATA_W-1:0] rx_byte,
  output logic              rx_ready,
  output logic              fifo_write_n,
  output logic              parity_err,
  output logic              framing_err,
  output logic              overflow
);

  logic                rx_sync;
  logic                rx_fall;
  logic [STATE_W-1:0]  state;
  logic [STATE_W-1:0]  state_nxt;
  logic [SAMPLE_W-1:0] sample_cnt;
  logic [BITCNT_W-1:0] bit_cnt;
  logic [DATA_W-1:0]   data_sr;
  logic                par_pend;
  logic                frm_pend;
  logic                tick_c;
  logic                last_bit_c;
  logic                commit_c;
  logic                load_c;
  logic                write_c;
  logic                ovf_set_c;

  uart_rx_sync u_sync (
    .clk     (clk),
    .reset_n (reset_n),
    .rx      (rx),
    .rx_sync (rx_sync),
    .rx_fall (rx_fall)
  );

  assign tick_c     = baud_clock && (sample_cnt == SAMPLE_W'(SAMPLE_POINT));
  assign last_bit_c = (bit_cnt == (bit8 ? BITCNT_W'(7) : BITCNT_W'(6)));

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= rx_idle;
    else          state <= state_nxt;
  end

  // Next state plus commit-cycle decisions.
  always_comb begin
    state_nxt = state;
    commit_c  = 1'b0;
    load_c    = 1'b0;
    write_c   = 1'b0;
    ovf_set_c = 1'b0;
    case (state)
      rx_idle:   if (rx_fall) state_nxt = rx_start;
      rx_start:  if (tick_c) state_nxt = rx_sync ? rx_idle : rx_data;
      rx_data:   if (tick_c && last_bit_c) state_nxt = parity_en ? rx_parity : rx_stop;
      rx_parity: if (tick_c) state_nxt = rx_stop;
      rx_stop:   if (tick_c) state_nxt = rx_commit;
      rx_commit: begin
        state_nxt = rx_idle;
        commit_c  = 1'b1;
        if (RX_FIFO) begin
          write_c = ~fifo_full;
          load_c  = ~fifo_full;
        end else begin
          load_c  = ~rx_ready | read_rx_byte;
        end
        ovf_set_c = ~load_c;
      end
      default:   state_nxt = rx_idle;
    endcase
  end

  // Oversampling counter, bit counter, shift register and pending errors.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sample_cnt <= '0;
      bit_cnt    <= '0;
      data_sr    <= '0;
      par_pend   <= 1'b0;
      frm_pend   <= 1'b0;
    end else begin
      if (state == rx_idle)  sample_cnt <= '0;
      else if (baud_clock)   sample_cnt <= sample_cnt + SAMPLE_W'(1);

      if (state == rx_start)             bit_cnt <= '0;
      else if (state == rx_data && tick_c) bit_cnt <= bit_cnt + BITCNT_W'(1);

      if (state == rx_idle && rx_fall) begin
        data_sr  <= '0;
        par_pend <= 1'b0;
        frm_pend <= 1'b0;
      end
      if (state == rx_data && tick_c)   data_sr[bit_cnt] <= rx_sync;
      if (state == rx_parity && tick_c) par_pend <= (rx_sync != parity_expect(data_sr, odd_n_even));
      if (state == rx_stop && tick_c)   frm_pend <= ~rx_sync;
    end
  end

  // Registered host-facing outputs; a flag set in the commit cycle beats clear_status.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rx_byte      <= '0;
      rx_ready     <= 1'b0;
      fifo_write_n <= 1'b1;
      parity_err   <= 1'b0;
      framing_err  <= 1'b0;
      overflow     <= 1'b0;
    end else begin
      if (load_c) rx_byte <= data_sr;
      if (RX_FIFO)           rx_ready <= 1'b0;
      else if (load_c)       rx_ready <= 1'b1;
      else if (read_rx_byte) rx_ready <= 1'b0;
      fifo_write_n <= ~write_c;
      parity_err   <= (commit_c & par_pend) | (parity_err & ~clear_status);
      framing_err  <= (commit_c & frm_pend) | (framing_err & ~clear_status);
      overflow     <= ovf_set_c | (overflow & ~clear_status);
    end
  end

endmodule
